// File: rtl/axis_v_out_sync.sv
// AXI4-Stream video slave to native video-timing output (egress bridge).
// Free-running timing generator; stream pixels fill active slots once locked.
//
// Ports:
//   vclk, resetn         clock, async active-low reset (release synced)
//   s_axis_t*            AXIS slave: tdata/tvalid/tready/tuser(SOF)/tlast(EOL)
//   vid_data             pixel out, 0 outside active or when unlocked
//   vid_active_video     data enable
//   vid_hblank/vblank    blanking flags
//   vid_hsync/vsync      sync pulses, polarity set by SYNC_POL
//   locked               stream aligned to timing
//   err_pulse, err_cnt   lock-loss pulse and saturating count
module axis_v_out_sync #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned H_ACTIVE   = 1920,
    parameter int unsigned H_FP       = 88,
    parameter int unsigned H_SYNC     = 44,
    parameter int unsigned H_BP       = 148,
    parameter int unsigned V_ACTIVE   = 1080,
    parameter int unsigned V_FP       = 4,
    parameter int unsigned V_SYNC     = 5,
    parameter int unsigned V_BP       = 36,
    parameter bit          SYNC_POL   = 1'b1
) (
    input  logic                  vclk,
    input  logic                  resetn,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tuser,
    input  logic                  s_axis_tlast,
    output logic [DATA_WIDTH-1:0] vid_data,
    output logic                  vid_active_video,
    output logic                  vid_hblank,
    output logic                  vid_vblank,
    output logic                  vid_hsync,
    output logic                  vid_vsync,
    output logic                  locked,
    output logic                  err_pulse,
    output logic [7:0]            err_cnt
);

    localparam logic [15:0] H_ACT  = 16'(H_ACTIVE);
    localparam logic [15:0] H_LAST = 16'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [15:0] HS_BEG = 16'(H_ACTIVE + H_FP);
    localparam logic [15:0] HS_END = 16'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [15:0] V_ACT  = 16'(V_ACTIVE);
    localparam logic [15:0] V_LAST = 16'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [15:0] VS_BEG = 16'(V_ACTIVE + V_FP);
    localparam logic [15:0] VS_END = 16'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic        S_OFF  = ~SYNC_POL;

    typedef enum logic [1:0] {
        S_SEARCH,
        S_WAIT,
        S_LOCKED
    } state_t;

    // Reset asserts immediately, releases two vclk edges later.
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge vclk or negedge resetn) begin
        if (!resetn) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_q[1];

    logic [15:0] hcnt_q, hcnt_d;
    logic [15:0] vcnt_q, vcnt_d;
    logic        h_wrap, v_wrap;
    logic        pix_act, sof_pos, eol_pos;
    logic        hs, vs;

    assign h_wrap  = (hcnt_q == H_LAST);
    assign v_wrap  = (vcnt_q == V_LAST);
    assign pix_act = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
    assign sof_pos = (hcnt_q == 16'd0) && (vcnt_q == 16'd0);
    assign eol_pos = (hcnt_q == H_ACT - 16'd1);
    assign hs      = (hcnt_q >= HS_BEG) && (hcnt_q < HS_END);
    assign vs      = (vcnt_q >= VS_BEG) && (vcnt_q < VS_END);

    always_comb begin
        hcnt_d = hcnt_q + 16'd1;
        vcnt_d = vcnt_q;
        if (h_wrap) begin
            hcnt_d = 16'd0;
            vcnt_d = v_wrap ? 16'd0 : vcnt_q + 16'd1;
        end
    end

    state_t state_q, state_d;
    logic   tready_c;
    logic   err;
    logic   take;

    always_comb begin
        state_d  = state_q;
        tready_c = 1'b0;
        err      = 1'b0;
        take     = 1'b0;
        unique case (state_q)
            S_SEARCH: begin
                // Drop everything up to SOF; SOF itself stays on the bus.
                tready_c = ~(s_axis_tvalid & s_axis_tuser);
                if (s_axis_tvalid && s_axis_tuser) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (h_wrap && v_wrap) begin
                    state_d = S_LOCKED;
                end
            end
            S_LOCKED: begin
                tready_c = pix_act;
                if (pix_act) begin
                    if (!s_axis_tvalid
                        || (s_axis_tuser != sof_pos)
                        || (s_axis_tlast != eol_pos)) begin
                        err     = 1'b1;
                        state_d = S_SEARCH;
                    end else begin
                        take = 1'b1;
                    end
                end
            end
            default: state_d = S_SEARCH;
        endcase
    end

    assign s_axis_tready = tready_c & rst_n;

    logic [DATA_WIDTH-1:0] vid_data_q;
    logic                  active_q, hblank_q, vblank_q;
    logic                  hsync_q, vsync_q;
    logic                  err_pulse_q;
    logic [7:0]            err_cnt_q, err_cnt_d;

    assign err_cnt_d = (err && (err_cnt_q != 8'hFF)) ? err_cnt_q + 8'd1
                                                      : err_cnt_q;

    always_ff @(posedge vclk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt_q      <= 16'd0;
            vcnt_q      <= 16'd0;
            state_q     <= S_SEARCH;
            vid_data_q  <= '0;
            active_q    <= 1'b0;
            hblank_q    <= 1'b1;
            vblank_q    <= 1'b1;
            hsync_q     <= S_OFF;
            vsync_q     <= S_OFF;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= 8'd0;
        end else begin
            hcnt_q      <= hcnt_d;
            vcnt_q      <= vcnt_d;
            state_q     <= state_d;
            vid_data_q  <= take ? s_axis_tdata : '0;
            active_q    <= pix_act;
            hblank_q    <= (hcnt_q >= H_ACT);
            vblank_q    <= (vcnt_q >= V_ACT);
            hsync_q     <= hs ^ S_OFF;
            vsync_q     <= vs ^ S_OFF;
            err_pulse_q <= err;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign vid_data         = vid_data_q;
    assign vid_active_video = active_q;
    assign vid_hblank       = hblank_q;
    assign vid_vblank       = vblank_q;
    assign vid_hsync        = hsync_q;
    assign vid_vsync        = vsync_q;
    assign locked           = (state_q == S_LOCKED);
    assign err_pulse        = err_pulse_q;
    assign err_cnt          = err_cnt_q;

endmodule

// File: tb/tb_axis_v_out_sync.sv
// Bench for axis_v_out_sync: small 14x7 raster, AXIS source queue,
// expected-pixel scoreboard drained by a monitor on active_video.
module tb_axis_v_out_sync;

    localparam int NS = 300;

    logic        vclk = 1'b0;
    logic        resetn = 1'b1;
    logic [15:0] s_axis_tdata = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic        s_axis_tuser = 1'b0;
    logic        s_axis_tlast = 1'b0;
    logic [15:0] vid_data;
    logic        vid_active_video;
    logic        vid_hblank;
    logic        vid_vblank;
    logic        vid_hsync;
    logic        vid_vsync;
    logic        locked;
    logic        err_pulse;
    logic [7:0]  err_cnt;

    axis_v_out_sync #(
        .DATA_WIDTH(16),
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SYNC_POL(1'b1)
    ) dut (
        .vclk(vclk),
        .resetn(resetn),
        .s_axis_tdata(s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .s_axis_tuser(s_axis_tuser),
        .s_axis_tlast(s_axis_tlast),
        .vid_data(vid_data),
        .vid_active_video(vid_active_video),
        .vid_hblank(vid_hblank),
        .vid_vblank(vid_vblank),
        .vid_hsync(vid_hsync),
        .vid_vsync(vid_vsync),
        .locked(locked),
        .err_pulse(err_pulse),
        .err_cnt(err_cnt)
    );

    always #5 vclk = ~vclk;

    typedef struct {
        logic [15:0] d;
        logic        u;
        logic        l;
        int          gap;
    } beat_t;

    beat_t       src_q[$];
    logic [15:0] exp_q[$];
    int          n_chk = 0;
    int          n_pass = 0;
    int          n_errp = 0;
    int          n_pix = 0;

    bit a_act[NS];
    bit a_hb[NS];
    bit a_vb[NS];
    bit a_hs[NS];
    bit a_vs[NS];
    int n_lk;
    int n_nz;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic int rise(input bit a[NS], input int from);
        for (int i = (from < 1 ? 1 : from); i < NS; i++)
            if (a[i] && !a[i-1]) return i;
        return -1;
    endfunction

    function automatic int fall(input bit a[NS], input int from);
        for (int i = (from < 1 ? 1 : from); i < NS; i++)
            if (!a[i] && a[i-1]) return i;
        return -1;
    endfunction

    function automatic bit at(input bit a[NS], input int i);
        if (i >= 0 && i < NS) return a[i];
        return 1'b0;
    endfunction

    // AXIS source: one offer per cycle, handshake sampled before the edge.
    initial begin
        bit acc;
        forever begin
            @(negedge vclk);
            if (src_q.size() > 0 && src_q[0].gap > 0) begin
                src_q[0].gap = src_q[0].gap - 1;
                s_axis_tvalid = 1'b0;
            end else if (src_q.size() > 0) begin
                s_axis_tvalid = 1'b1;
                s_axis_tdata  = src_q[0].d;
                s_axis_tuser  = src_q[0].u;
                s_axis_tlast  = src_q[0].l;
            end else begin
                s_axis_tvalid = 1'b0;
            end
            #4;
            acc = s_axis_tvalid && s_axis_tready;
            @(posedge vclk);
            if (acc && src_q.size() > 0) void'(src_q.pop_front());
        end
    end

    // Monitor: every active pixel pops one expected value (when queued).
    initial begin
        logic [15:0] e;
        forever begin
            @(negedge vclk);
            if (err_pulse) n_errp++;
            if (vid_active_video && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk($sformatf("pixel%0d", n_pix), 32'(vid_data), 32'(e));
                n_pix++;
            end
        end
    end

    task automatic push_frame(input logic [15:0] base, input int bad_last,
                              input int gap_at);
        beat_t b;
        for (int i = 0; i < 32; i++) begin
            b.d   = base + 16'(i);
            b.u   = (i == 0);
            b.l   = ((i % 8) == 7) || (i == bad_last);
            b.gap = (i == gap_at) ? 1 : 0;
            src_q.push_back(b);
        end
    endtask

    task automatic push_exp(input logic [15:0] base, input int n_data,
                            input int n_zero);
        for (int i = 0; i < n_data; i++) exp_q.push_back(base + 16'(i));
        for (int i = 0; i < n_zero; i++) exp_q.push_back(16'h0);
    endtask

    task automatic check_reset_vals(input string p);
        chk({p, "_rst_data"},   32'(vid_data), 32'h0);
        chk({p, "_rst_active"}, 32'(vid_active_video), 32'h0);
        chk({p, "_rst_hblank"}, 32'(vid_hblank), 32'h1);
        chk({p, "_rst_vblank"}, 32'(vid_vblank), 32'h1);
        chk({p, "_rst_hsync"},  32'(vid_hsync), 32'h0);
        chk({p, "_rst_vsync"},  32'(vid_vsync), 32'h0);
        chk({p, "_rst_tready"}, 32'(s_axis_tready), 32'h0);
        chk({p, "_rst_locked"}, 32'(locked), 32'h0);
        chk({p, "_rst_errp"},   32'(err_pulse), 32'h0);
        chk({p, "_rst_errcnt"}, 32'(err_cnt), 32'h0);
    endtask

    // Asserts reset between edges so the async path is what clears outputs.
    task automatic do_reset(input string p);
        @(posedge vclk);
        #2;
        resetn = 1'b0;
        #1;
        check_reset_vals(p);
        src_q.delete();
        exp_q.delete();
        n_errp = 0;
        repeat (3) @(posedge vclk);
    endtask

    task automatic release_rst();
        @(negedge vclk);
        resetn = 1'b1;
    endtask

    task automatic drain(input string p, input int budget);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            @(negedge vclk);
            n++;
        end
        chk({p, "_drain_left"}, 32'(exp_q.size()), 32'h0);
    endtask

    task automatic wait_errp(input string p, input int budget);
        int n;
        n = 0;
        @(negedge vclk);
        while (!err_pulse && n < budget) begin
            @(negedge vclk);
            n++;
        end
        chk({p, "_errp_seen"}, 32'(err_pulse), 32'h1);
    endtask

    initial begin
        int a0, a1, h0, v0, v1, b0, n;

        // Timing only, no stream.
        do_reset("t1");
        release_rst();
        n_lk = 0;
        n_nz = 0;
        for (int i = 0; i < NS; i++) begin
            @(negedge vclk);
            a_act[i] = vid_active_video;
            a_hb[i]  = vid_hblank;
            a_vb[i]  = vid_vblank;
            a_hs[i]  = vid_hsync;
            a_vs[i]  = vid_vsync;
            if (locked) n_lk++;
            if (vid_data != 16'h0) n_nz++;
        end
        a0 = rise(a_act, 1);
        a1 = rise(a_act, a0 + 1);
        h0 = rise(a_hs, a0);
        v0 = rise(a_vs, 1);
        v1 = rise(a_vs, v0 + 1);
        b0 = rise(a_vb, a0);
        chk("t1_line_period", 32'(a1 - a0), 32'd14);
        chk("t1_hblank_act",  32'(at(a_hb, a0)), 32'h0);
        chk("t1_hblank_fp",   32'(at(a_hb, a0 + 8)), 32'h1);
        chk("t1_hsync_pos",   32'(h0 - a0), 32'd10);
        chk("t1_hsync_w2",    32'(at(a_hs, h0 + 1)), 32'h1);
        chk("t1_hsync_end",   32'(at(a_hs, h0 + 2)), 32'h0);
        chk("t1_vsync_line",  32'(v0 - a0), 32'd70);
        chk("t1_vsync_width", 32'(fall(a_vs, v0) - v0), 32'd14);
        chk("t1_frame_len",   32'(v1 - v0), 32'd98);
        chk("t1_vblank_pos",  32'(b0 - a0), 32'd56);
        chk("t1_vblank_len",  32'(fall(a_vb, b0) - b0), 32'd42);
        chk("t1_locked_cnt",  32'(n_lk), 32'd0);
        chk("t1_data_nz",     32'(n_nz), 32'd0);

        // Continuous stream: one unlocked frame, then two data frames.
        do_reset("t2");
        push_frame(16'h0100, -1, -1);
        push_frame(16'h0200, -1, -1);
        push_exp(16'h0, 0, 32);
        push_exp(16'h0100, 32, 0);
        push_exp(16'h0200, 32, 0);
        release_rst();
        drain("t2", 400);
        @(negedge vclk);
        chk("t2_locked", 32'(locked), 32'h1);
        chk("t2_errcnt", 32'(err_cnt), 32'h0);

        // Junk before SOF is dropped, SOF is held until frame start.
        do_reset("t3");
        for (int i = 0; i < 5; i++) begin
            beat_t b;
            b.d = 16'hBAD0 + 16'(i);
            b.u = 1'b0;
            b.l = 1'b0;
            b.gap = 0;
            src_q.push_back(b);
        end
        push_frame(16'h0300, -1, -1);
        push_exp(16'h0, 0, 32);
        push_exp(16'h0300, 32, 0);
        release_rst();
        repeat (20) @(negedge vclk);
        chk("t3_sof_held_tready", 32'(s_axis_tready), 32'h0);
        chk("t3_junk_dropped", 32'(src_q.size()), 32'd32);
        drain("t3", 300);
        chk("t3_errcnt", 32'(err_cnt), 32'h0);

        // Underflow at line 2 pixel 3, relock on next SOF frame.
        do_reset("t4");
        push_frame(16'h0400, -1, 19);
        push_frame(16'h0500, -1, -1);
        push_frame(16'h0600, -1, -1);
        push_exp(16'h0, 0, 32);
        push_exp(16'h0400, 19, 13);
        push_exp(16'h0500, 32, 0);
        release_rst();
        wait_errp("t4", 400);
        chk("t4_err_locked",  32'(locked), 32'h0);
        chk("t4_err_active",  32'(vid_active_video), 32'h1);
        chk("t4_err_data",    32'(vid_data), 32'h0);
        drain("t4", 400);
        chk("t4_relocked", 32'(locked), 32'h1);
        chk("t4_errcnt",   32'(err_cnt), 32'd1);
        chk("t4_errp_cnt", 32'(n_errp), 32'd1);

        // Reset mid-line 2 of a locked frame.
        n = 0;
        while (src_q.size() > 12 && n < 300) begin
            @(negedge vclk);
            n++;
        end
        chk("t6_reach_line2", 32'(src_q.size()), 32'd12);
        do_reset("t6");
        push_frame(16'h0700, -1, -1);
        push_frame(16'h0800, -1, -1);
        push_exp(16'h0, 0, 32);
        push_exp(16'h0700, 32, 0);
        push_exp(16'h0800, 32, 0);
        release_rst();
        drain("t6", 400);
        chk("t6_relocked", 32'(locked), 32'h1);
        chk("t6_errcnt",   32'(err_cnt), 32'h0);

        // Early tlast, then 300 forced errors to saturate err_cnt.
        do_reset("t5");
        push_frame(16'h0900, 6, -1);
        for (int i = 0; i < 300; i++) begin
            beat_t b;
            b.d = 16'hA000 + 16'(i);
            b.u = 1'b1;
            b.l = 1'b1;
            b.gap = 0;
            src_q.push_back(b);
        end
        push_exp(16'h0, 0, 32);
        push_exp(16'h0900, 6, 26);
        release_rst();
        wait_errp("t5", 400);
        chk("t5_first_errcnt", 32'(err_cnt), 32'd1);
        chk("t5_first_locked", 32'(locked), 32'h0);
        n = 0;
        while (src_q.size() > 0 && n < 32000) begin
            @(negedge vclk);
            n++;
        end
        chk("t5_src_done", 32'(src_q.size()), 32'h0);
        repeat (4) @(negedge vclk);
        chk("t5_errcnt_sat", 32'(err_cnt), 32'd255);
        chk("t5_errp_cnt",   32'(n_errp), 32'd301);
        chk("t5_locked",     32'(locked), 32'h0);
        chk("t5_scoreboard", 32'(exp_q.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: timeout, %0d/%0d checks passed",
                 n_pass, n_chk);
        $fatal(1, "watchdog");
    end

endmodule
